// File: rtl/sw_debounce.sv
// Purpose: synchronise and debounce WIDTH slide-switch lines, report per-bit changes and a sticky change irq.
// Latency: a raw level held from before edge k reaches sw_o at edge k+SYNC_STAGES+STABLE_CYCLES-1.
// Backpressure: none; outputs are free-running registered levels/pulses, irq_o held until acknowledged.
module sw_debounce #(
    parameter int WIDTH         = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 10000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] sw_raw_i,
    output logic [WIDTH-1:0] sw_o,
    output logic [WIDTH-1:0] change_mask_o,
    output logic             changed_o,
    output logic             irq_o,
    input  logic             irq_ack_i
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    // Count value at which the next mismatching sample completes the stability window.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [CNT_W-1:0] cnt_q  [WIDTH];
    logic [CNT_W-1:0] cnt_d  [WIDTH];
    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] sw_q;
    logic [WIDTH-1:0] sw_d;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic             chg_q;
    logic             irq_q;
    logic             irq_d;

    // Last synchroniser stage is the only copy of the pin the debounce logic looks at.
    assign sync_s = sync_q[SYNC_STAGES-1];

    // Plain flop chain per bit; nothing may sit between stages.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= sw_raw_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Per-bit stability counters, commit decision, change mask and irq next state.
    always_comb begin
        sw_d = sw_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync_s[i] != sw_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    sw_d[i] = sync_s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        mask_d = sw_d ^ sw_q;
        // A commit on the same edge as an ack keeps the request asserted.
        irq_d = irq_q;
        if (|mask_d) begin
            irq_d = 1'b1;
        end else if (irq_ack_i) begin
            irq_d = 1'b0;
        end
    end

    // Register counters and all outputs; reset discards any partial count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            sw_q   <= '0;
            mask_q <= '0;
            chg_q  <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            sw_q   <= sw_d;
            mask_q <= mask_d;
            chg_q  <= |mask_d;
            irq_q  <= irq_d;
        end
    end

    assign sw_o          = sw_q;
    assign change_mask_o = mask_q;
    assign changed_o     = chg_q;
    assign irq_o         = irq_q;

endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Front-end conditioner for the 16 board slide switches; sits directly upstream of the switch system-bus controller and drives its sw_i input.
- Synchronises each raw switch line into clk_i and debounces it with a per-bit stability counter.
- Reports which bits changed and holds a sticky change-interrupt request until it is acknowledged.

Parameters:
WIDTH, 16, number of switch lines.
SYNC_STAGES, 2, flip-flop stages in the per-bit synchroniser; legal range is 2 or more.
STABLE_CYCLES, 10000, number of consecutive synchronised cycles a new level must hold before it is accepted; legal range is 1 or more.

Ports:
clk_i  input  1  system clock.
rst_i  input  1  asynchronous, active-high reset.
sw_raw_i  input  WIDTH  raw, asynchronous, bouncing switch pins.
sw_o  output  WIDTH  debounced switch levels; connects to the bus controller's sw_i.
change_mask_o  output  WIDTH  one-cycle pulse per bit whose sw_o value changed on this edge.
changed_o  output  1  one-cycle pulse; equals the OR of change_mask_o.
irq_o  output  1  sticky change-interrupt request.
irq_ack_i  input  1  clears irq_o; sampled on the clock edge.

Behaviour:
- Reset (async assert; deassertion is synchronised externally):
  - All synchroniser flops = 0.
  - All counters = 0.
  - sw_o = 0, change_mask_o = 0, changed_o = 0, irq_o = 0.
  - Takes effect immediately when asserted mid-count; any partial count is discarded.
- Synchroniser:
  - Per bit, a SYNC_STAGES-deep shift chain; the last stage is s[i].
  - No logic is placed between the stages.
- Debounce, per bit i, on each clk_i edge:
  - s[i] == sw_o[i]: cnt[i] <= 0.
  - s[i] != sw_o[i] and cnt[i] == STABLE_CYCLES-1: sw_o[i] <= s[i], cnt[i] <= 0.
  - s[i] != sw_o[i] otherwise: cnt[i] <= cnt[i]+1.
- Counter width: $clog2(STABLE_CYCLES+1) bits. The counter never exceeds STABLE_CYCLES-1, so it cannot wrap.
- Latency:
  - Raw level stable from before edge k: sw_o updates at edge k+SYNC_STAGES+STABLE_CYCLES-1.
  - Example: SYNC_STAGES=2, STABLE_CYCLES=4 gives update at edge k+5.
- Glitch rejection:
  - Any return of s[i] to sw_o[i] before the count completes resets cnt[i] to 0. No output change results.
  - A mismatch of STABLE_CYCLES-1 cycles or less never propagates.
- Independence: bits are fully independent. Several bits may commit on the same edge, and their change_mask_o bits assert together.
- Change report:
  - change_mask_o is registered on the same edge as the sw_o update. Each bit = old sw_o XOR new sw_o.
  - It is high for exactly one cycle, then returns to 0 unless another commit occurs.
  - changed_o is registered as the OR of the next change mask, so it is cycle-aligned with change_mask_o.
- irq_o:
  - Set on the edge where any bit commits.
  - Cleared on an edge where irq_ack_i=1 and no bit commits.
  - Set and ack on the same edge: set wins, irq_o stays 1.
  - Ack while irq_o=0 has no effect.
- Outputs are registered only. No combinational path from sw_raw_i or irq_ack_i to any output.
- Bus side: sw_o is held between commits. A bus read always sees a clean, stable value.

Test Plan:
Use STABLE_CYCLES=4, SYNC_STAGES=2 for simulation.

1. Reset then single press:
   - Stimulus: rst_i pulse; then sw_raw_i=16'h0001 held from before edge k.
   - Response: sw_o=0, change_mask_o=0, irq_o=0 through edge k+4.
   - At edge k+5: sw_o=16'h0001, change_mask_o=16'h0001, changed_o=1, irq_o=1.
   - At edge k+6: change_mask_o=0, changed_o=0, irq_o stays 1.
2. Bounce rejection:
   - Stimulus: bit 3 toggles 1,0,1,0 every 2 cycles, then settles at 1.
   - Response: no change_mask_o activity during the bounce.
   - sw_o[3] rises exactly 5 edges after the final settle sample; one pulse only.
3. Three-cycle glitch:
   - Stimulus: sw_raw_i[15] high for exactly 3 cycles, then low.
   - Response: sw_o stays 16'h0000, changed_o never pulses, irq_o stays 0.
4. Simultaneous multi-bit change:
   - Stimulus: sw_raw_i goes 16'h0000 to 16'hA5A5 in one cycle.
   - Response: single edge with sw_o=16'hA5A5, change_mask_o=16'hA5A5, changed_o=1.
   - Release to 16'h0000: change_mask_o=16'hA5A5 again, sw_o=0.
5. irq handshake:
   - Pulse irq_ack_i with no commit: irq_o drops on that edge.
   - Ack coincident with a new commit: irq_o remains 1.
   - Ack while irq_o=0: irq_o remains 0.
6. Reset mid-count:
   - Stimulus: bit 0 mismatched for 2 cycles, assert rst_i asynchronously between edges, release, keep sw_raw_i[0]=1.
   - Response: outputs drop to 0 immediately on assert.
   - After release, the count restarts from 0 and the full 5-edge latency applies.
